// File: rtl/player_seq_if.sv
// Handshake bundle between the player lifecycle sequencer and its neighbours:
// button/collision inputs in, gating and sprite controls out.
interface player_seq_if;
  logic       frame;
  logic       start;
  logic       fire;
  logic       hit;
  logic       bullet_active;
  logic       move_en;
  logic       player_visible;
  logic       explode_active;
  logic       fire_req;
  logic       done;
  logic [3:0] lives;
  logic       game_over;
  logic [2:0] state;

  modport master (
    output frame, start, fire, hit, bullet_active,
    input  move_en, player_visible, explode_active, fire_req, done, lives, game_over, state
  );

  modport slave (
    input  frame, start, fire, hit, bullet_active,
    output move_en, player_visible, explode_active, fire_req, done, lives, game_over, state
  );
endinterface

// File: rtl/player_seq.sv
// Frame-synchronous player lifecycle sequencer: lives, explosion, respawn, game over, fire gating.
// Optional invulnerability window after respawn is enabled by defining PLAYER_SEQ_INVULN_EN.
module player_seq #(
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned EXPLODE_FRAMES = 60,
  parameter int unsigned RESPAWN_FRAMES = 30,
  parameter int unsigned FIRE_COOLDOWN  = 20
`ifdef PLAYER_SEQ_INVULN_EN
  ,
  parameter int unsigned INVULN_FRAMES  = 90
`endif
) (
  input logic         clk,
  input logic         rst,
  player_seq_if.slave bus
);

  localparam int unsigned SEQ_MAX = (EXPLODE_FRAMES > RESPAWN_FRAMES) ? EXPLODE_FRAMES : RESPAWN_FRAMES;
`ifdef PLAYER_SEQ_INVULN_EN
  localparam int unsigned CNT_MAX = (SEQ_MAX > INVULN_FRAMES) ? SEQ_MAX : INVULN_FRAMES;
`else
  localparam int unsigned CNT_MAX = SEQ_MAX;
`endif
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned COOL_W  = $clog2(FIRE_COOLDOWN + 2);
  localparam int unsigned LIVES_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_PLAY    = 3'b001,
    S_EXPLODE = 3'b010,
    S_RESPAWN = 3'b011,
    S_OVER    = 3'b100
  } state_t;

  state_t               st;
  logic [CNT_W-1:0]     cnt;
  logic [COOL_W-1:0]    cool;
  logic [LIVES_W-1:0]   lives;
  logic                 start_q;
  logic                 fire_q;
  logic                 move_en;
  logic                 player_visible;
  logic                 explode_active;
  logic                 fire_req;
  logic                 done;
  logic                 game_over;

  logic                 start_rise;
  logic                 fire_rise;
  logic                 hit_ok;
  logic                 fire_ok;

  assign start_rise = bus.start & ~start_q;
  assign fire_rise  = bus.fire  & ~fire_q;

`ifdef PLAYER_SEQ_INVULN_EN
  logic [CNT_W-1:0]     inv;
  logic [CNT_W-1:0]     inv_elapsed;

  // Frames elapsed in the window once the current frame pulse is consumed.
  assign inv_elapsed = CNT_W'(INVULN_FRAMES) - inv + CNT_W'(1);
  assign hit_ok      = (st == S_PLAY) & bus.hit & (inv == '0);
`else
  assign hit_ok      = (st == S_PLAY) & bus.hit;
`endif

  // A hit in the same cycle swallows the shot.
  assign fire_ok = (st == S_PLAY) & fire_rise & ~bus.bullet_active & (cool == '0) & ~hit_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= S_IDLE;
      cnt            <= '0;
      cool           <= '0;
      lives          <= '0;
      // Edge registers come up armed so a button held through reset needs a release first.
      start_q        <= 1'b1;
      fire_q         <= 1'b1;
      move_en        <= 1'b0;
      player_visible <= 1'b0;
      explode_active <= 1'b0;
      fire_req       <= 1'b0;
      done           <= 1'b0;
      game_over      <= 1'b0;
`ifdef PLAYER_SEQ_INVULN_EN
      inv            <= '0;
`endif
    end else begin
      start_q  <= bus.start;
      fire_q   <= bus.fire;
      fire_req <= 1'b0;
      done     <= 1'b0;

      if (bus.frame && (cool != '0)) begin
        cool <= cool - COOL_W'(1);
      end
      if (fire_ok) begin
        fire_req <= 1'b1;
        cool     <= COOL_W'(FIRE_COOLDOWN);
      end

      case (st)
        S_IDLE, S_OVER: begin
          if (start_rise) begin
            st             <= S_PLAY;
            lives          <= LIVES_W'(LIVES_INIT);
            cool           <= '0;
            done           <= 1'b1;
            move_en        <= 1'b1;
            player_visible <= 1'b1;
            game_over      <= 1'b0;
`ifdef PLAYER_SEQ_INVULN_EN
            inv            <= '0;
`endif
          end
        end

        S_PLAY: begin
          if (hit_ok) begin
            st             <= S_EXPLODE;
            lives          <= (lives != '0) ? lives - LIVES_W'(1) : '0;
            cnt            <= '0;
            move_en        <= 1'b0;
            player_visible <= 1'b0;
            explode_active <= 1'b1;
          end
`ifdef PLAYER_SEQ_INVULN_EN
          // Blink in 8-frame phases while invulnerable, ending visible.
          else if (bus.frame && (inv != '0)) begin
            inv <= inv - CNT_W'(1);
            if (inv == CNT_W'(1)) begin
              player_visible <= 1'b1;
            end else if (inv_elapsed[2:0] == 3'b000) begin
              player_visible <= ~player_visible;
            end
          end
`endif
        end

        S_EXPLODE: begin
          if (cnt == CNT_W'(EXPLODE_FRAMES)) begin
            cnt            <= '0;
            explode_active <= 1'b0;
            if (lives == '0) begin
              st        <= S_OVER;
              game_over <= 1'b1;
            end else begin
              st   <= S_RESPAWN;
              done <= 1'b1;
            end
          end else if (bus.frame) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_RESPAWN: begin
          if (cnt == CNT_W'(RESPAWN_FRAMES)) begin
            st             <= S_PLAY;
            cnt            <= '0;
            move_en        <= 1'b1;
            player_visible <= 1'b1;
`ifdef PLAYER_SEQ_INVULN_EN
            inv            <= CNT_W'(INVULN_FRAMES);
`endif
          end else if (bus.frame) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          st             <= S_IDLE;
          cnt            <= '0;
          move_en        <= 1'b0;
          player_visible <= 1'b0;
          explode_active <= 1'b0;
          game_over      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.move_en        = move_en;
  assign bus.player_visible = player_visible;
  assign bus.explode_active = explode_active;
  assign bus.fire_req       = fire_req;
  assign bus.done           = done;
  assign bus.lives          = lives;
  assign bus.game_over      = game_over;
  assign bus.state          = st;

endmodule

// File: tb/tb_player_seq.sv
// Scoreboarded bench for player_seq: expected done/fire_req pulses are queued
// as stimulus is driven and popped by a negedge monitor when the DUT pulses.
module tb_player_seq;

  localparam logic [2:0] ST_IDLE    = 3'b000;
  localparam logic [2:0] ST_PLAY    = 3'b001;
  localparam logic [2:0] ST_EXPLODE = 3'b010;
  localparam logic [2:0] ST_RESPAWN = 3'b011;
  localparam logic [2:0] ST_OVER    = 3'b100;
  localparam logic [1:0] K_DONE     = 2'b10;
  localparam logic [1:0] K_FIRE     = 2'b01;
  localparam int         FRAME_PER  = 8;

  typedef struct {
    logic [1:0] kind;
    logic [2:0] st;
    logic [3:0] lives;
  } pulse_t;

  logic   clk;
  logic   rst;
  int     n_chk  = 0;
  int     n_pass = 0;
  int     fcnt   = 0;
  pulse_t sb[$];
  logic   done_prev;

  player_seq_if bus ();

  player_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input logic [1:0] k, input logic [2:0] s, input logic [3:0] l);
    pulse_t p;
    p.kind  = k;
    p.st    = s;
    p.lives = l;
    sb.push_back(p);
  endtask

  task automatic wait_frames(input int n);
    int seen = 0;
    for (int i = 0; i < n * FRAME_PER + 16 && seen < n; i++) begin
      @(negedge clk);
      if (bus.frame) seen++;
    end
    chk("wait_frames", 32'(seen), 32'(n));
  endtask

  // Called at a negedge; returns at the first negedge where state differs from s.
  task automatic wait_leave(input logic [2:0] s, input int budget, output int nfr);
    nfr = 0;
    for (int i = 0; i < budget && bus.state == s; i++) begin
      if (bus.frame) nfr++;
      @(negedge clk);
    end
  endtask

  // Returns at posedge+1 of the cycle whose inputs are sampled together with a frame pulse.
  task automatic align_frame();
    int guard = 0;
    @(negedge clk);
    while (!bus.frame && guard < 4 * FRAME_PER) begin
      @(negedge clk);
      guard++;
    end
    chk("align_frame", 32'(bus.frame), 32'd1);
    repeat (FRAME_PER) cyc();
  endtask

  task automatic fire_edge();
    bus.fire = 1'b1;
    cyc();
    bus.fire = 1'b0;
    cyc();
  endtask

  // Free-running frame pulse, one cycle every FRAME_PER clocks.
  initial begin
    bus.frame = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      fcnt++;
      bus.frame = (fcnt % FRAME_PER == 0);
    end
  end

  // Pulse monitor: every done/fire_req must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      done_prev <= 1'b0;
    end else begin
      if (bus.done) chk("done_back_to_back", 32'(done_prev), 32'd0);
      if (bus.done || bus.fire_req) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'({bus.done, bus.fire_req}), 32'd0);
        end else begin
          pulse_t p;
          p = sb.pop_front();
          chk("pulse_kind",  32'({bus.done, bus.fire_req}), 32'(p.kind));
          chk("pulse_state", 32'(bus.state), 32'(p.st));
          chk("pulse_lives", 32'(bus.lives), 32'(p.lives));
        end
      end
      done_prev <= bus.done;
    end
  end

  initial begin
    int nfr;
    rst               = 1'b1;
    bus.start         = 1'b1;
    bus.fire          = 1'b0;
    bus.hit           = 1'b0;
    bus.bullet_active = 1'b0;

    // Reset with start held: must stay in IDLE after release.
    repeat (3) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_state",     32'(bus.state), 32'(ST_IDLE));
    chk("rst_lives",     32'(bus.lives), 32'd0);
    chk("rst_move_en",   32'(bus.move_en), 32'd0);
    chk("rst_visible",   32'(bus.player_visible), 32'd0);
    chk("rst_explode",   32'(bus.explode_active), 32'd0);
    chk("rst_fire_req",  32'(bus.fire_req), 32'd0);
    chk("rst_done",      32'(bus.done), 32'd0);
    chk("rst_game_over", 32'(bus.game_over), 32'd0);
    bus.start = 1'b0;
    cyc();

    // Start edge: done pulse, PLAY, full lives.
    expect_pulse(K_DONE, ST_PLAY, 4'd3);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    @(negedge clk);
    chk("start_state",   32'(bus.state), 32'(ST_PLAY));
    chk("start_lives",   32'(bus.lives), 32'd3);
    chk("start_move_en", 32'(bus.move_en), 32'd1);
    chk("start_visible", 32'(bus.player_visible), 32'd1);

    // Fire, reject inside cooldown, accept after 20 frames.
    cyc();
    expect_pulse(K_FIRE, ST_PLAY, 4'd3);
    bus.fire = 1'b1;
    cyc();
    bus.fire = 1'b0;
    wait_frames(5);
    cyc();
    fire_edge();
    wait_frames(15);
    cyc();
    expect_pulse(K_FIRE, ST_PLAY, 4'd3);
    fire_edge();

    // Bullet in flight blocks; held fire does not auto-repeat.
    wait_frames(20);
    cyc();
    bus.bullet_active = 1'b1;
    bus.fire          = 1'b1;
    repeat (2) cyc();
    bus.bullet_active = 1'b0;
    repeat (5) cyc();
    bus.fire = 1'b0;
    cyc();
    expect_pulse(K_FIRE, ST_PLAY, 4'd3);
    fire_edge();

    // Hit and fire edge together: hit wins.
    wait_frames(20);
    cyc();
    expect_pulse(K_DONE, ST_RESPAWN, 4'd2);
    bus.hit  = 1'b1;
    bus.fire = 1'b1;
    cyc();
    bus.hit  = 1'b0;
    bus.fire = 1'b0;
    @(negedge clk);
    chk("hit1_state",   32'(bus.state), 32'(ST_EXPLODE));
    chk("hit1_lives",   32'(bus.lives), 32'd2);
    chk("hit1_move_en", 32'(bus.move_en), 32'd0);
    chk("hit1_visible", 32'(bus.player_visible), 32'd0);
    chk("hit1_explode", 32'(bus.explode_active), 32'd1);
    wait_leave(ST_EXPLODE, 60 * FRAME_PER + 40, nfr);
    chk("explode1_frames", 32'(nfr), 32'd60);
    chk("explode1_next",   32'(bus.state), 32'(ST_RESPAWN));
    chk("respawn_explode", 32'(bus.explode_active), 32'd0);
    wait_leave(ST_RESPAWN, 30 * FRAME_PER + 40, nfr);
    chk("respawn1_frames", 32'(nfr), 32'd30);
    chk("respawn1_next",   32'(bus.state), 32'(ST_PLAY));
    chk("respawn1_move",   32'(bus.move_en), 32'd1);

`ifdef PLAYER_SEQ_INVULN_EN
    // Invulnerable for INVULN_FRAMES frames after respawn.
    wait_frames(10);
    cyc();
    bus.hit = 1'b1;
    cyc();
    bus.hit = 1'b0;
    @(negedge clk);
    chk("inv_hit_state", 32'(bus.state), 32'(ST_PLAY));
    chk("inv_hit_lives", 32'(bus.lives), 32'd2);
    wait_frames(80);
    cyc();
    expect_pulse(K_DONE, ST_RESPAWN, 4'd1);
    bus.hit = 1'b1;
    cyc();
    bus.hit = 1'b0;
`else
    // Hit sampled at the end of the first PLAY cycle after respawn is accepted.
    expect_pulse(K_DONE, ST_RESPAWN, 4'd1);
    bus.hit = 1'b1;
    cyc();
    bus.hit = 1'b0;
`endif
    @(negedge clk);
    chk("hit2_state", 32'(bus.state), 32'(ST_EXPLODE));
    chk("hit2_lives", 32'(bus.lives), 32'd1);
    wait_leave(ST_EXPLODE, 60 * FRAME_PER + 40, nfr);
    chk("explode2_frames", 32'(nfr), 32'd60);
    wait_leave(ST_RESPAWN, 30 * FRAME_PER + 40, nfr);
    chk("respawn2_next", 32'(bus.state), 32'(ST_PLAY));

`ifdef PLAYER_SEQ_INVULN_EN
    wait_frames(95);
`endif
    // Last life lost on a cycle that also carries a frame pulse.
    align_frame();
    bus.hit = 1'b1;
    cyc();
    bus.hit = 1'b0;
    @(negedge clk);
    chk("hit3_state", 32'(bus.state), 32'(ST_EXPLODE));
    chk("hit3_lives", 32'(bus.lives), 32'd0);
    wait_leave(ST_EXPLODE, 60 * FRAME_PER + 40, nfr);
    chk("explode3_frames", 32'(nfr), 32'd60);
    chk("over_state",      32'(bus.state), 32'(ST_OVER));
    chk("over_game_over",  32'(bus.game_over), 32'd1);
    chk("over_move_en",    32'(bus.move_en), 32'd0);
    chk("over_visible",    32'(bus.player_visible), 32'd0);

    // Hit outside PLAY is ignored.
    cyc();
    bus.hit = 1'b1;
    cyc();
    bus.hit = 1'b0;
    @(negedge clk);
    chk("over_hit_state", 32'(bus.state), 32'(ST_OVER));
    chk("over_hit_lives", 32'(bus.lives), 32'd0);

    // Restart from OVER.
    cyc();
    expect_pulse(K_DONE, ST_PLAY, 4'd3);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    @(negedge clk);
    chk("restart_state", 32'(bus.state), 32'(ST_PLAY));
    chk("restart_lives", 32'(bus.lives), 32'd3);
    chk("restart_over",  32'(bus.game_over), 32'd0);

    // Reset in the middle of an explosion.
    cyc();
    bus.hit = 1'b1;
    cyc();
    bus.hit = 1'b0;
    wait_frames(10);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_state",   32'(bus.state), 32'(ST_IDLE));
    chk("midrst_lives",   32'(bus.lives), 32'd0);
    chk("midrst_explode", 32'(bus.explode_active), 32'd0);
    chk("midrst_move",    32'(bus.move_en), 32'd0);
    chk("midrst_visible", 32'(bus.player_visible), 32'd0);
    chk("midrst_over",    32'(bus.game_over), 32'd0);
    chk("midrst_done",    32'(bus.done), 32'd0);

    repeat (4) cyc();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
